// File: rtl/decrypter.sv
// Receive-side XOR/rotating-key decrypter: word accepted under req_in/rdy_in, plaintext under req_out/rdy_out.
// Latency: data_out/req_out valid one edge after the accept edge; SEND holds the word indefinitely while rdy_out=0.
module decrypter #(
    parameter int DATA_WIDTH = 32,
    parameter int KEY_WIDTH  = 32,
    parameter int ROT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  prog,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ROT_WIDTH-1:0]  rot_offset,
    input  logic                  rdy_in,
    input  logic                  rdy_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  req_in,
    output logic                  req_out,
    output logic [1:0]            state,
    output logic                  key_valid,
    output logic [15:0]           word_count,
    output logic                  err_no_key
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IN = 2'd1,
        DECRYPT = 2'd2,
        SEND    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [KEY_WIDTH-1:0]  key_q, key_d;
    logic [DATA_WIDTH-1:0] cipher_q, cipher_d;
    logic [ROT_WIDTH-1:0]  rot_q, rot_d;
    logic [DATA_WIDTH-1:0] data_out_d;
    logic                  req_in_d, req_out_d, key_valid_d, err_d;
    logic [15:0]           word_cnt_q, word_cnt_d;

    // Rotate by shifting a doubled key: offset 0 yields the key itself,
    // with no shift-by-full-width corner case.
    logic [31:0]            rot_mod;
    logic [2*KEY_WIDTH-1:0] key_dbl;
    logic [KEY_WIDTH-1:0]   key_rot;

    assign rot_mod = 32'(rot_q) % 32'(KEY_WIDTH);
    assign key_dbl = {key_q, key_q} << rot_mod;
    assign key_rot = key_dbl[2*KEY_WIDTH-1 -: KEY_WIDTH];

    assign state      = state_q;
    assign word_count = word_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            key_q      <= '0;
            cipher_q   <= '0;
            rot_q      <= '0;
            data_out   <= '0;
            req_in     <= 1'b0;
            req_out    <= 1'b0;
            key_valid  <= 1'b0;
            err_no_key <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            cipher_q   <= cipher_d;
            rot_q      <= rot_d;
            data_out   <= data_out_d;
            req_in     <= req_in_d;
            req_out    <= req_out_d;
            key_valid  <= key_valid_d;
            err_no_key <= err_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (prog) state_d = WAIT_IN;
            WAIT_IN: if (!prog && rdy_in) state_d = DECRYPT;
            DECRYPT: state_d = SEND;
            SEND:    if (rdy_out) state_d = WAIT_IN;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; prog and rdy_in only matter
    // in IDLE/WAIT_IN, so the key never changes mid-word.
    always_comb begin
        key_d       = key_q;
        cipher_d    = cipher_q;
        rot_d       = rot_q;
        data_out_d  = data_out;
        req_in_d    = req_in;
        req_out_d   = req_out;
        key_valid_d = key_valid;
        err_d       = err_no_key;
        word_cnt_d  = word_cnt_q;
        case (state_q)
            IDLE: begin
                if (prog) begin
                    key_d       = data_in;
                    key_valid_d = 1'b1;
                    req_in_d    = 1'b1;
                end else if (rdy_in) begin
                    err_d = 1'b1;
                end
            end
            WAIT_IN: begin
                if (prog) begin
                    key_d = data_in;
                end else if (rdy_in) begin
                    cipher_d = data_in;
                    rot_d    = rot_offset;
                    req_in_d = 1'b0;
                end
            end
            DECRYPT: begin
                data_out_d = cipher_q ^ key_rot;
                req_out_d  = 1'b1;
            end
            SEND: begin
                if (rdy_out) begin
                    req_out_d  = 1'b0;
                    req_in_d   = 1'b1;
                    word_cnt_d = word_cnt_q + 16'd1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_decrypter.sv
// Bench for decrypter: vector table, hand-written corner sequences, and a queue
// scoreboard fed by a behavioural encrypter for the loopback run.
module tb_decrypter;

    logic        clk = 1'b0;
    logic        reset, prog, rdy_in, rdy_out;
    logic [31:0] data_in;
    logic [4:0]  rot_offset;
    logic [31:0] data_out;
    logic        req_in, req_out, key_valid, err_no_key;
    logic [1:0]  state;
    logic [15:0] word_count;

    decrypter dut (
        .clk        (clk),
        .reset      (reset),
        .prog       (prog),
        .data_in    (data_in),
        .rot_offset (rot_offset),
        .rdy_in     (rdy_in),
        .rdy_out    (rdy_out),
        .data_out   (data_out),
        .req_in     (req_in),
        .req_out    (req_out),
        .state      (state),
        .key_valid  (key_valid),
        .word_count (word_count),
        .err_no_key (err_no_key)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] key;
        logic [4:0]  off;
        logic [31:0] cipher;
        logic [31:0] plain;
    } vec_t;

    vec_t        vecs[6];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [15:0] exp_count;

    function automatic logic [31:0] rotl(input logic [31:0] k, input int s);
        logic [31:0] r = k;
        for (int i = 0; i < s; i++) r = {r[30:0], r[31]};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard pop: a word is delivered when req_out and rdy_out meet.
    always @(negedge clk) begin
        if (reset === 1'b0 && req_out === 1'b1 && rdy_out === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_unexpected: got %h expected no word", data_out);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (data_out === e) n_pass++;
                else $display("FAIL scoreboard_plain: got %h expected %h", data_out, e);
            end
        end
    end

    task automatic program_key(input logic [31:0] k);
        prog    = 1'b1;
        data_in = k;
        tick();
        prog    = 1'b0;
        check("prog_key_valid", 32'(key_valid), 1);
        check("prog_state", 32'(state), 1);
        check("prog_req_in", 32'(req_in), 1);
    endtask

    task automatic send_word(input logic [31:0] cipher, input logic [4:0] off,
                             input logic [31:0] plain, input int hold, input bit noise);
        int waited = 0;
        while (req_in !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        check("wait_req_in", 32'(req_in), 1);
        if (req_in !== 1'b1) return;
        data_in    = cipher;
        rot_offset = off;
        rdy_in     = 1'b1;
        exp_q.push_back(plain);
        tick();
        rdy_in  = 1'b0;
        data_in = $urandom;
        check("accept_state", 32'(state), 2);
        check("accept_req_out", 32'(req_out), 0);
        check("accept_req_in", 32'(req_in), 0);
        tick();
        check("decrypt_req_out", 32'(req_out), 1);
        check("decrypt_state", 32'(state), 3);
        check("decrypt_data", data_out, plain);
        for (int i = 0; i < hold; i++) begin
            rdy_in  = noise && i[0];
            prog    = noise && !i[0];
            data_in = $urandom;
            tick();
            check("hold_data", data_out, plain);
            check("hold_req_out", 32'(req_out), 1);
            check("hold_req_in", 32'(req_in), 0);
            check("hold_state", 32'(state), 3);
        end
        rdy_in  = 1'b0;
        prog    = 1'b0;
        rdy_out = 1'b1;
        tick();
        rdy_out   = 1'b0;
        exp_count = exp_count + 16'd1;
        check("send_req_out", 32'(req_out), 0);
        check("send_req_in", 32'(req_in), 1);
        check("send_state", 32'(state), 1);
        check("word_count", 32'(word_count), 32'(exp_count));
        check("data_kept", data_out, plain);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] k, p;
        logic [4:0]  o;

        vecs[0] = '{32'h000000FF, 5'd4,  32'h12345678, 32'h12345988};
        vecs[1] = '{32'hFFFF0000, 5'd0,  32'hA5A5A5A5, 32'h5A5AA5A5};
        vecs[2] = '{32'h80000001, 5'd31, 32'hC0000000, 32'h00000000};
        vecs[3] = '{32'h12345678, 5'd8,  32'h00000000, 32'h34567812};
        vecs[4] = '{32'hF0000000, 5'd1,  32'hFFFFFFFF, 32'h1FFFFFFE};
        vecs[5] = '{32'h00000001, 5'd31, 32'h00000000, 32'h80000000};

        reset = 1'b1; prog = 1'b0; rdy_in = 1'b0; rdy_out = 1'b0;
        data_in = '0; rot_offset = '0; exp_count = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_data_out", data_out, 0);
        check("rst_req_in", 32'(req_in), 0);
        check("rst_req_out", 32'(req_out), 0);
        check("rst_key_valid", 32'(key_valid), 0);
        check("rst_word_count", 32'(word_count), 0);
        check("rst_err", 32'(err_no_key), 0);
        reset = 1'b0;
        tick();

        // Cipher word before any key: dropped, sticky error.
        rdy_in  = 1'b1;
        data_in = 32'h00001234;
        tick();
        rdy_in = 1'b0;
        check("nokey_err", 32'(err_no_key), 1);
        check("nokey_state", 32'(state), 0);
        check("nokey_req_out", 32'(req_out), 0);
        check("nokey_key_valid", 32'(key_valid), 0);
        tick();
        check("nokey_req_out_later", 32'(req_out), 0);
        program_key(32'h000000FF);
        check("nokey_err_sticky", 32'(err_no_key), 1);

        foreach (vecs[i]) begin
            program_key(vecs[i].key);
            send_word(vecs[i].cipher, vecs[i].off, vecs[i].plain, 0, 1'b0);
        end
        check("err_still_set", 32'(err_no_key), 1);

        // Long stall in SEND with stray rdy_in/prog pulses that must be ignored.
        k = 32'h0F0F1234;
        program_key(k);
        send_word(32'hDEADBEEF ^ rotl(k, 13), 5'd13, 32'hDEADBEEF, 10, 1'b1);
        send_word(32'hCAFEF00D ^ rotl(k, 7), 5'd7, 32'hCAFEF00D, 0, 1'b0);

        // prog and rdy_in together in WAIT_IN: reload wins, no capture.
        k       = 32'h00F000F0;
        prog    = 1'b1;
        rdy_in  = 1'b1;
        data_in = k;
        tick();
        prog   = 1'b0;
        rdy_in = 1'b0;
        check("prio_state", 32'(state), 1);
        check("prio_req_in", 32'(req_in), 1);
        send_word(32'h11111111 ^ rotl(k, 3), 5'd3, 32'h11111111, 1, 1'b0);

        // Loopback against a behavioural encrypter, reprogramming between words.
        k = $urandom;
        program_key(k);
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom;
                program_key(k);
            end
            p = $urandom;
            o = 5'($urandom_range(0, 31));
            send_word(p ^ rotl(k, int'(o)), o, p, $urandom_range(0, 2), 1'b0);
        end
        check("loopback_drained", 32'(exp_q.size()), 0);

        // word_count wrap from a preset value.
        @(negedge clk);
        force dut.word_cnt_q = 16'hFFFE;
        #1;
        release dut.word_cnt_q;
        exp_count = 16'hFFFE;
        tick();
        send_word(32'h0 ^ rotl(k, 1), 5'd1, 32'h0, 0, 1'b0);
        send_word(32'h5 ^ rotl(k, 2), 5'd2, 32'h5, 0, 1'b0);
        check("wrap_zero", 32'(word_count), 0);

        // Reset asserted while a word waits in SEND.
        program_key(32'h13579BDF);
        rdy_in     = 1'b1;
        data_in    = 32'h2468ACE0;
        rot_offset = 5'd5;
        tick();
        rdy_in = 1'b0;
        tick();
        check("pre_rst_state", 32'(state), 3);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_state", 32'(state), 0);
        check("mid_rst_data_out", data_out, 0);
        check("mid_rst_req_out", 32'(req_out), 0);
        check("mid_rst_req_in", 32'(req_in), 0);
        check("mid_rst_key_valid", 32'(key_valid), 0);
        check("mid_rst_word_count", 32'(word_count), 0);
        check("mid_rst_err", 32'(err_no_key), 0);
        exp_q.delete();
        exp_count = '0;
        tick();
        reset = 1'b0;
        tick();
        rdy_in = 1'b1;
        tick();
        rdy_in = 1'b0;
        check("post_rst_err", 32'(err_no_key), 1);
        check("post_rst_state", 32'(state), 0);
        check("post_rst_req_out", 32'(req_out), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
